csma_access_scheduler: RTL and testbench
========================================

// Module: csma_access_scheduler
// PURPOSE
//  CSMA/CA channel-access scheduler that sits in front of the single Manchester transmitter.
//  Two requesters share the transmitter: the frame transmit controller (data) and the receiver's ACK generator (ack).
//  Enforces DIFS, SIFS, random slotted backoff with binary-exponential contention window, ACK timeout and retry limit.
//  Grants the transmitter to exactly one requester at a time.
// PARAMETERS
//  DIFS_TICKS        80    idle ticks required before data contention
//  SIFS_TICKS        40    ticks between request and ACK grant; cardet ignored
//  SLOT_TICKS        8     ticks per backoff slot
//  CW_MIN_LOG2       2     initial contention window = 2**CW_MIN_LOG2 slots
//  CW_MAX_LOG2       5     contention window ceiling, 1..8
//  ACK_TIMEOUT_TICKS 256   ticks to wait for an ACK after a data frame
//  MAX_ATTEMPTS      5     total data transmissions before failure, 1..7
//  LFSR_SEED         8'hA5 backoff LFSR reset value; must be nonzero
// PORTS
//  clk            in   1  clock
//  rst            in   1  synchronous, active-high reset
//  tick           in   1  one-cycle bit-time enable; all timers advance only on tick
//  cardet         in   1  carrier detected; medium busy
//  data_req       in   1  level; data frame pending; held until data_grant or abandoned
//  data_needs_ack in   1  sampled on the cycle data_grant rises
//  ack_req        in   1  level; ACK pending; held until ack_grant
//  tx_done        in   1  pulse; granted frame fully sent
//  ack_rcvd       in   1  pulse; valid ACK addressed to us
//  data_grant     out  1  transmitter owned by data path
//  ack_grant      out  1  transmitter owned by ACK path
//  retry          out  1  pulse; data frame must be resent from its start
//  tx_ok          out  1  pulse; data frame delivered
//  tx_fail        out  1  pulse; MAX_ATTEMPTS exhausted
//  attempt        out  3  current attempt number; 0 when idle
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, timer 0, backoff 0, cw=CW_MIN_LOG2, LFSR=LFSR_SEED.
//  All outputs registered. data_grant and ack_grant are never both 1.
//  LFSR: 8-bit, x^8+x^6+x^5+x^4+1, advances every clk.
//  Draw: backoff = lfsr & ((1<<cw)-1).
//  Timer: increments on tick and clears on state entry. "N ticks elapsed" = tick while timer==N-1.
//  IDLE:
//   - ack_req -> SIFS.
//   - else data_req -> DIFS; attempt=1; cw=CW_MIN_LOG2; draw backoff.
//  DIFS:
//   - ack_req -> SIFS; backoff and attempt kept.
//   - !data_req -> IDLE; attempt=0; no pulse.
//   - tick&cardet -> timer=0.
//   - DIFS_TICKS idle elapsed -> GRANT_DATA if backoff==0, else BACKOFF.
//  BACKOFF:
//   - ack_req / !data_req: same handling as DIFS.
//   - tick&cardet -> DIFS; remaining backoff frozen.
//   - each SLOT_TICKS elapsed -> backoff--; at 0 -> GRANT_DATA.
//  GRANT_DATA: data_grant=1; latch data_needs_ack on entry.
//   - tx_done -> ACK_WAIT if latched, else tx_ok pulse -> IDLE.
//  ACK_WAIT:
//   - ack_rcvd -> tx_ok pulse, IDLE. ack_rcvd wins over a same-cycle timeout.
//   - ACK_TIMEOUT_TICKS elapsed and attempt==MAX_ATTEMPTS -> tx_fail pulse, IDLE.
//   - ACK_TIMEOUT_TICKS elapsed otherwise -> attempt++; cw=min(cw+1,CW_MAX_LOG2); retry pulse; draw backoff; DIFS.
//   - ack_req ignored until leaving ACK_WAIT (stays pending).
//  SIFS: SIFS_TICKS elapsed -> GRANT_ACK; cardet ignored.
//  GRANT_ACK: ack_grant=1.
//   - tx_done -> DIFS if attempt!=0 and data_req (resume, backoff kept), else IDLE.
//  Ignored: tx_done outside GRANT_*; ack_rcvd outside ACK_WAIT.
//  Grant outputs rise one cycle after the qualifying tick and drop the cycle after tx_done.
//  tx_ok, tx_fail and retry are single-cycle pulses; attempt clears to 0 in the same cycle.
//  rst mid-operation: next cycle = reset state; grants drop immediately.
// TESTING
//  T1: data_req, cardet=0, tick every clk, LFSR forced draw 0 -> data_grant after 80 ticks; tx_done, needs_ack=0 -> tx_ok, attempt 0.
//  T2: draw 3, cardet pulse at slot 2 of BACKOFF -> return to DIFS, full 80 ticks, then 1 slot (8 ticks) -> data_grant.
//  T3: ack_req while in BACKOFF -> ack_grant after 40 ticks with cardet=1; tx_done -> DIFS resumes with frozen backoff.
//  T4: needs_ack=1, no ack_rcvd -> retry pulse after 256 ticks each attempt, cw 2->3->4->5->5; tx_fail after attempt 5.
//  T5: needs_ack=1, ack_rcvd at tick 100 of ACK_WAIT -> tx_ok, no retry; ack_rcvd and timeout same cycle -> tx_ok.
//  T6: rst asserted during GRANT_DATA -> data_grant=0, attempt=0 next cycle; data_req held -> fresh DIFS.

Source files
------------

// File: rtl/csma_access_scheduler.sv
// CSMA/CA channel-access scheduler for the shared Manchester transmitter.
// Arbitrates between the data-frame controller and the ACK generator,
// enforcing DIFS/SIFS spacing, slotted random backoff with a binary-exponential
// contention window, ACK timeout and a bounded retry count.
module csma_access_scheduler #(
    parameter int         DIFS_TICKS        = 80,
    parameter int         SIFS_TICKS        = 40,
    parameter int         SLOT_TICKS        = 8,
    parameter int         CW_MIN_LOG2       = 2,
    parameter int         CW_MAX_LOG2       = 5,
    parameter int         ACK_TIMEOUT_TICKS = 256,
    parameter int         MAX_ATTEMPTS      = 5,
    parameter logic [7:0] LFSR_SEED         = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       cardet,
    input  logic       data_req,
    input  logic       data_needs_ack,
    input  logic       ack_req,
    input  logic       tx_done,
    input  logic       ack_rcvd,
    output logic       data_grant,
    output logic       ack_grant,
    output logic       retry,
    output logic       tx_ok,
    output logic       tx_fail,
    output logic [2:0] attempt
);

    // The timer must reach the longest interval the FSM ever measures.
    localparam int SPAN_A = (DIFS_TICKS > SIFS_TICKS) ? DIFS_TICKS : SIFS_TICKS;
    localparam int SPAN_B = (SLOT_TICKS > ACK_TIMEOUT_TICKS) ? SLOT_TICKS : ACK_TIMEOUT_TICKS;
    localparam int SPAN   = (SPAN_A > SPAN_B) ? SPAN_A : SPAN_B;
    localparam int TW     = $clog2(SPAN + 1);

    // "N ticks elapsed" means a tick arrives while the timer holds N-1.
    localparam logic [TW-1:0] DIFS_LAST = TW'(DIFS_TICKS - 1);
    localparam logic [TW-1:0] SIFS_LAST = TW'(SIFS_TICKS - 1);
    localparam logic [TW-1:0] SLOT_LAST = TW'(SLOT_TICKS - 1);
    localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_TIMEOUT_TICKS - 1);

    localparam logic [3:0] CW_MIN      = 4'(CW_MIN_LOG2);
    localparam logic [3:0] CW_MAX      = 4'(CW_MAX_LOG2);
    localparam logic [2:0] ATTEMPT_MAX = 3'(MAX_ATTEMPTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIFS,
        S_BACKOFF,
        S_GRANT_DATA,
        S_ACK_WAIT,
        S_SIFS,
        S_GRANT_ACK
    } state_t;

    state_t        state_reg;
    logic [TW-1:0] timer_reg;
    logic [7:0]    backoff_reg;
    logic [3:0]    cw_reg;
    logic [7:0]    lfsr_reg;
    logic          needs_ack_reg;

    logic [3:0]    cw_grow;
    logic [7:0]    min_mask;
    logic [7:0]    grow_mask;
    logic          difs_done;
    logic          sifs_done;
    logic          slot_done;
    logic          ack_timeout;
    logic          busy_tick;

    // Window after a failed attempt: one step wider, saturating at the ceiling.
    assign cw_grow = (cw_reg < CW_MAX) ? (cw_reg + 4'd1) : CW_MAX;

    // Draw masks: bit gi is kept when the window (log2) exceeds gi, i.e. (1<<cw)-1.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_mask
            assign min_mask[gi]  = (CW_MIN > 4'(gi));
            assign grow_mask[gi] = (cw_grow > 4'(gi));
        end
    endgenerate

    assign difs_done   = tick && (timer_reg == DIFS_LAST);
    assign sifs_done   = tick && (timer_reg == SIFS_LAST);
    assign slot_done   = tick && (timer_reg == SLOT_LAST);
    assign ack_timeout = tick && (timer_reg == ACK_LAST);
    assign busy_tick   = tick && cardet;

    // Free-running Fibonacci LFSR, x^8+x^6+x^5+x^4+1, stepping every clock so
    // the draw depends on when a request happens to arrive.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
        end
    end

    // Access FSM with registered grants, pulses and attempt counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            timer_reg     <= '0;
            backoff_reg   <= '0;
            cw_reg        <= CW_MIN;
            needs_ack_reg <= 1'b0;
            data_grant    <= 1'b0;
            ack_grant     <= 1'b0;
            retry         <= 1'b0;
            tx_ok         <= 1'b0;
            tx_fail       <= 1'b0;
            attempt       <= 3'd0;
        end else begin
            retry   <= 1'b0;
            tx_ok   <= 1'b0;
            tx_fail <= 1'b0;
            if (tick) begin
                timer_reg <= timer_reg + TW'(1);
            end

            case (state_reg)
                S_IDLE: begin
                    timer_reg <= '0;
                    // A pending ACK always goes first; it only needs SIFS.
                    if (ack_req) begin
                        state_reg <= S_SIFS;
                    end else if (data_req) begin
                        state_reg   <= S_DIFS;
                        attempt     <= 3'd1;
                        cw_reg      <= CW_MIN;
                        backoff_reg <= lfsr_reg & min_mask;
                    end
                end

                S_DIFS: begin
                    if (ack_req) begin
                        // Backoff and attempt survive the ACK detour.
                        state_reg <= S_SIFS;
                        timer_reg <= '0;
                    end else if (!data_req) begin
                        state_reg <= S_IDLE;
                        timer_reg <= '0;
                        attempt   <= 3'd0;
                    end else if (busy_tick) begin
                        // Any busy tick restarts the idle interval.
                        timer_reg <= '0;
                    end else if (difs_done) begin
                        timer_reg <= '0;
                        if (backoff_reg == 8'd0) begin
                            state_reg     <= S_GRANT_DATA;
                            data_grant    <= 1'b1;
                            needs_ack_reg <= data_needs_ack;
                        end else begin
                            state_reg <= S_BACKOFF;
                        end
                    end
                end

                S_BACKOFF: begin
                    if (ack_req) begin
                        state_reg <= S_SIFS;
                        timer_reg <= '0;
                    end else if (!data_req) begin
                        state_reg <= S_IDLE;
                        timer_reg <= '0;
                        attempt   <= 3'd0;
                    end else if (busy_tick) begin
                        // Medium taken: freeze the remaining slots and redo DIFS.
                        state_reg <= S_DIFS;
                        timer_reg <= '0;
                    end else if (slot_done) begin
                        timer_reg   <= '0;
                        backoff_reg <= backoff_reg - 8'd1;
                        if (backoff_reg == 8'd1) begin
                            state_reg     <= S_GRANT_DATA;
                            data_grant    <= 1'b1;
                            needs_ack_reg <= data_needs_ack;
                        end
                    end
                end

                S_GRANT_DATA: begin
                    timer_reg <= '0;
                    if (tx_done) begin
                        data_grant <= 1'b0;
                        if (needs_ack_reg) begin
                            state_reg <= S_ACK_WAIT;
                        end else begin
                            state_reg <= S_IDLE;
                            tx_ok     <= 1'b1;
                            attempt   <= 3'd0;
                        end
                    end
                end

                S_ACK_WAIT: begin
                    // A same-cycle ACK beats the timeout.
                    if (ack_rcvd) begin
                        state_reg <= S_IDLE;
                        timer_reg <= '0;
                        tx_ok     <= 1'b1;
                        attempt   <= 3'd0;
                    end else if (ack_timeout) begin
                        timer_reg <= '0;
                        if (attempt == ATTEMPT_MAX) begin
                            state_reg <= S_IDLE;
                            tx_fail   <= 1'b1;
                            attempt   <= 3'd0;
                        end else begin
                            state_reg   <= S_DIFS;
                            retry       <= 1'b1;
                            attempt     <= attempt + 3'd1;
                            cw_reg      <= cw_grow;
                            backoff_reg <= lfsr_reg & grow_mask;
                        end
                    end
                end

                S_SIFS: begin
                    // Carrier is deliberately ignored: the ACK owns this gap.
                    if (sifs_done) begin
                        state_reg <= S_GRANT_ACK;
                        timer_reg <= '0;
                        ack_grant <= 1'b1;
                    end
                end

                S_GRANT_ACK: begin
                    timer_reg <= '0;
                    if (tx_done) begin
                        ack_grant <= 1'b0;
                        if ((attempt != 3'd0) && data_req) begin
                            // Resume the interrupted contention with its frozen backoff.
                            state_reg <= S_DIFS;
                        end else begin
                            state_reg <= S_IDLE;
                            attempt   <= 3'd0;
                        end
                    end
                end

                default: begin
                    state_reg  <= S_IDLE;
                    timer_reg  <= '0;
                    data_grant <= 1'b0;
                    ack_grant  <= 1'b0;
                    attempt    <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csma_access_scheduler.sv
// Scoreboard bench for csma_access_scheduler: stimulus pushes expected output
// events (kind, cycle, attempt); a negedge monitor pops and compares them.
module tb_csma_access_scheduler;

    localparam int         DIFS  = 80;
    localparam int         SIFS  = 40;
    localparam int         SLOT  = 8;
    localparam int         ACKTO = 256;
    localparam int         MAXA  = 5;
    localparam int         CWMIN = 2;
    localparam int         CWMAX = 5;
    localparam logic [7:0] SEED  = 8'hA5;

    logic       clk = 1'b0;
    logic       rst, tick, cardet, data_req, data_needs_ack, ack_req, tx_done, ack_rcvd;
    logic       data_grant, ack_grant, retry, tx_ok, tx_fail;
    logic [2:0] attempt;

    typedef enum int {EV_DGRANT, EV_AGRANT, EV_RETRY, EV_OK, EV_FAIL} ev_t;
    typedef struct {
        ev_t        kind;
        int         when;
        logic [2:0] att;
    } exp_t;

    exp_t       sb[$];
    int         compared = 0;
    int         failed   = 0;
    int         cyc      = 0;
    logic [7:0] m;
    logic       prev_dg = 1'b0;
    logic       prev_ag = 1'b0;

    always #5 clk = ~clk;

    csma_access_scheduler #(
        .DIFS_TICKS(DIFS), .SIFS_TICKS(SIFS), .SLOT_TICKS(SLOT),
        .CW_MIN_LOG2(CWMIN), .CW_MAX_LOG2(CWMAX), .ACK_TIMEOUT_TICKS(ACKTO),
        .MAX_ATTEMPTS(MAXA), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .cardet(cardet),
        .data_req(data_req), .data_needs_ack(data_needs_ack), .ack_req(ack_req),
        .tx_done(tx_done), .ack_rcvd(ack_rcvd),
        .data_grant(data_grant), .ack_grant(ack_grant), .retry(retry),
        .tx_ok(tx_ok), .tx_fail(tx_fail), .attempt(attempt)
    );

    // Cycle counter and reference LFSR (x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) m <= SEED;
        else     m <= {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
    end

    function automatic logic [7:0] mask_of(input int cw);
        logic [8:0] full;
        full = (9'd1 << cw) - 9'd1;
        return full[7:0];
    endfunction

    function automatic void push(input ev_t k, input int when, input int att);
        exp_t e;
        e.kind = k;
        e.when = when;
        e.att  = 3'(att);
        sb.push_back(e);
    endfunction

    task automatic observe(input ev_t k);
        exp_t e;
        compared++;
        if (sb.size() == 0) begin
            failed++;
            $display("FAIL unexpected_event: got %s at cycle %0d attempt %0d, required no event", k.name(), cyc, attempt);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.when != cyc || e.att !== attempt) begin
                failed++;
                $display("FAIL event: got %s cycle %0d attempt %0d, required %s cycle %0d attempt %0d",
                         k.name(), cyc, attempt, e.kind.name(), e.when, e.att);
            end else begin
                $display("txn %s cycle %0d attempt %0d ok", k.name(), cyc, attempt);
            end
        end
    endtask

    // Monitor: detect grant rises and pulses, compare against the scoreboard.
    always @(negedge clk) begin
        if (data_grant === 1'b1 && ack_grant === 1'b1) begin
            failed++;
            $display("FAIL grant_exclusive: data_grant=1 ack_grant=1 at cycle %0d, required at most one", cyc);
        end
        if (data_grant === 1'b1 && prev_dg !== 1'b1) observe(EV_DGRANT);
        if (ack_grant === 1'b1 && prev_ag !== 1'b1)  observe(EV_AGRANT);
        if (retry === 1'b1)   observe(EV_RETRY);
        if (tx_ok === 1'b1)   observe(EV_OK);
        if (tx_fail === 1'b1) observe(EV_FAIL);
        prev_dg <= data_grant;
        prev_ag <= ack_grant;
    end

    task automatic chk(input string name, input logic [2:0] got, input logic [2:0] req);
        compared++;
        if (got !== req) begin
            failed++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end else begin
            $display("check %s = %0d ok", name, got);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Wait for an IDLE-entry draw of 'want', then raise data_req; p0 is the sampling edge.
    task automatic start_data(input logic [7:0] want, input logic need_ack, output int p0);
        int n;
        n = 0;
        while (((m & mask_of(CWMIN)) != want) && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) begin
            compared++;
            failed++;
            $display("FAIL draw_search: got no draw %0d within 400 cycles, required one", want);
        end
        data_needs_ack = need_ack;
        data_req       = 1'b1;
        p0             = cyc + 1;
    endtask

    // After grant at cycle g: send tx_done expecting an immediate tx_ok, then release data_req.
    task automatic finish_no_ack(input int g);
        wait_until(g + 2);
        push(EV_OK, cyc + 1, 0);
        tx_done = 1'b1;
        step();
        tx_done  = 1'b0;
        data_req = 1'b0;
        repeat (4) step();
    endtask

    task automatic pulse_cardet_at(input int c);
        wait_until(c - 1);
        cardet = 1'b1;
        step();
        cardet = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no completion by time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, g, d, t, q, x, cw, a;
        logic [7:0] draw;

        rst = 1'b1; tick = 1'b1; cardet = 1'b0; data_req = 1'b0; data_needs_ack = 1'b0;
        ack_req = 1'b0; tx_done = 1'b0; ack_rcvd = 1'b0;
        step(); step();
        chk("reset_data_grant", {2'b0, data_grant}, 3'd0);
        chk("reset_ack_grant",  {2'b0, ack_grant},  3'd0);
        chk("reset_retry",      {2'b0, retry},      3'd0);
        chk("reset_tx_ok",      {2'b0, tx_ok},      3'd0);
        chk("reset_tx_fail",    {2'b0, tx_fail},    3'd0);
        chk("reset_attempt",    attempt,            3'd0);
        rst = 1'b0;
        repeat (3) step();

        // T1: draw 0 -> grant exactly DIFS after the request, no ACK -> tx_ok.
        start_data(8'd0, 1'b0, p0);
        push(EV_DGRANT, p0 + DIFS, 1);
        finish_no_ack(p0 + DIFS);

        // T2: draw 3, busy tick in DIFS restarts it, busy tick in 3rd slot freezes backoff=1.
        start_data(8'd3, 1'b0, p0);
        push(EV_DGRANT, p0 + 218, 1);
        pulse_cardet_at(p0 + 30);
        pulse_cardet_at(p0 + 130);
        finish_no_ack(p0 + 218);

        // T3: ACK request during BACKOFF (after one slot) wins with carrier busy; data resumes.
        start_data(8'd3, 1'b0, p0);
        push(EV_AGRANT, p0 + 92 + SIFS, 1);
        wait_until(p0 + 91);
        ack_req = 1'b1;
        cardet  = 1'b1;
        wait_until(p0 + 92 + SIFS + 1);
        ack_req = 1'b0;
        wait_until(p0 + 92 + SIFS + 2);
        d = cyc + 1;
        push(EV_DGRANT, d + DIFS + 2 * SLOT, 1);
        tx_done = 1'b1;
        cardet  = 1'b0;
        step();
        tx_done = 1'b0;
        finish_no_ack(d + DIFS + 2 * SLOT);

        // T4: ACK never arrives: retries with cw 3,4,5,5 then tx_fail after attempt 5.
        start_data(8'd1, 1'b1, p0);
        g  = p0 + DIFS + SLOT;
        cw = CWMIN;
        push(EV_DGRANT, g, 1);
        for (a = 1; a <= MAXA; a++) begin
            wait_until(g + 1);
            d = cyc + 1;
            t = d + ACKTO;
            if (a < MAXA) push(EV_RETRY, t, a + 1);
            else          push(EV_FAIL, t, 0);
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            if (a < MAXA) begin
                cw = (cw + 1 > CWMAX) ? CWMAX : cw + 1;
                wait_until(t - 1);
                draw = m & mask_of(cw);
                g = t + DIFS + SLOT * int'(draw);
                push(EV_DGRANT, g, a + 1);
            end else begin
                wait_until(t);
                data_req = 1'b0;
            end
        end
        repeat (4) step();

        // T5a: ACK at tick 100 of ACK_WAIT -> tx_ok, no retry.
        // T5b: ACK on the timeout tick itself -> tx_ok wins.
        for (int k = 0; k < 2; k++) begin
            start_data(8'd0, 1'b1, p0);
            push(EV_DGRANT, p0 + DIFS, 1);
            wait_until(p0 + DIFS + 1);
            d = cyc + 1;
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            t = (k == 0) ? d + 100 : d + ACKTO;
            push(EV_OK, t, 0);
            wait_until(t - 1);
            ack_rcvd = 1'b1;
            step();
            ack_rcvd = 1'b0;
            data_req = 1'b0;
            repeat (4) step();
        end

        // T6: reset during GRANT_DATA drops the grant; held request starts a fresh DIFS.
        start_data(8'd0, 1'b0, p0);
        push(EV_DGRANT, p0 + DIFS, 1);
        wait_until(p0 + DIFS + 2);
        rst = 1'b1;
        x = cyc + 1;
        step();
        chk("rst_data_grant", {2'b0, data_grant}, 3'd0);
        chk("rst_attempt",    attempt,            3'd0);
        rst  = 1'b0;
        draw = m & mask_of(CWMIN);
        push(EV_DGRANT, x + 1 + DIFS + SLOT * int'(draw), 1);
        finish_no_ack(x + 1 + DIFS + SLOT * int'(draw));

        // T7: stray tx_done/ack_rcvd in IDLE are ignored; ACK from IDLE with tick every other clock.
        tx_done  = 1'b1;
        ack_rcvd = 1'b1;
        step();
        tx_done  = 1'b0;
        ack_rcvd = 1'b0;
        repeat (3) step();
        q = cyc + 1;
        ack_req = 1'b1;
        tick    = 1'b0;
        push(EV_AGRANT, q + 2 * SIFS, 0);
        while (cyc < q + 2 * SIFS + 1) begin
            step();
            tick = (((cyc + 1 - q) % 2) == 0);
        end
        tick    = 1'b1;
        ack_req = 1'b0;
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        repeat (6) step();
        chk("final_ack_grant", {2'b0, ack_grant}, 3'd0);
        chk("final_attempt",   attempt,           3'd0);

        compared++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: got %0d pending events, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
